// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-AEAD128 control path.
package ascon_pack;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_AD_WAIT = 3'd2,
        S_AD_RND  = 3'd3,
        S_PT_WAIT = 3'd4,
        S_PT_RND  = 3'd5,
        S_FIN     = 3'd6,
        S_DONE    = 3'd7
    } state_seq_t;

    // Round constants are indexed 0..11; shorter permutations start later.
    localparam logic [3:0] LAST_ROUND    = 4'd11;
    localparam logic [3:0] ROUND_START_A = 4'd0;
    localparam logic [3:0] ROUND_START_B = 4'd4;

    // Domain separation flips the least significant state bit.
    localparam int DSEP_BIT = 0;

    function automatic logic [3:0] round_start(input int unsigned rounds);
        return 4'(12 - rounds);
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round-constant index counter: loads a phase start value and counts to 11.
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       inc_i,
    output logic [3:0] round_o,
    output logic       last_round_o
);

    logic [3:0] round_q, round_d;
    logic [3:0] start_q, start_d;

    // Load wins over increment; stepping past 11 wraps to the phase start value.
    always_comb begin
        round_d = round_q;
        start_d = start_q;
        if (load_i) begin
            round_d = load_val_i;
            start_d = load_val_i;
        end else if (inc_i) begin
            round_d = (round_q >= LAST_ROUND) ? start_q : round_q + 4'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            round_q <= 4'd0;
            start_q <= 4'd0;
        end else begin
            round_q <= round_d;
            start_q <= start_d;
        end
    end

    assign round_o      = round_q;
    assign last_round_o = (round_q == LAST_ROUND);

endmodule

// File: rtl/ascon_sequencer.sv
// ASCON-AEAD128 phase sequencer: init (pa), AD blocks (pb), PT blocks (pb), finalization (pa).
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | waiting for start_i
//  INIT    | pa over IV||K||N, key XOR after last round
//  AD_WAIT | waiting for AD block; handshake cycle is first pb round
//  AD_RND  | remaining pb rounds of an AD block, dsep on last AD block
//  PT_WAIT | waiting for PT block; last PT block goes straight to FIN
//  PT_RND  | remaining pb rounds of a PT block
//  FIN     | pa over last block with key XORs on both sides
//  DONE    | tag presented (first cycle), done_o until next start_i
module ascon_sequencer
    import ascon_pack::*;
#(
    parameter int unsigned NB_AD_BLOCKS = 1,
    parameter int unsigned NB_PT_BLOCKS = 4,
    parameter int unsigned ROUNDS_A     = 12,
    parameter int unsigned ROUNDS_B     = 8
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       block_valid_i,
    output logic       block_ready_o,
    output logic       init_state_o,
    output logic       en_state_o,
    output logic [3:0] round_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_dsep_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       done_o
);

    localparam int unsigned BLK_MAX = (NB_AD_BLOCKS > NB_PT_BLOCKS) ? NB_AD_BLOCKS : NB_PT_BLOCKS;
    localparam int unsigned BLK_W   = $clog2(BLK_MAX + 1);
    localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(1);
    localparam logic [BLK_W-1:0] AD_LAST = BLK_W'(NB_AD_BLOCKS);
    localparam logic [BLK_W-1:0] PT_LAST = BLK_W'(NB_PT_BLOCKS);
    localparam logic [3:0]       RS_A    = round_start(ROUNDS_A);
    localparam logic [3:0]       RS_B    = round_start(ROUNDS_B);

    state_seq_t       state_q, state_d;
    logic [BLK_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [BLK_W-1:0] pt_cnt_q, pt_cnt_d;
    logic             tag_q, tag_d;

    logic       rc_load, rc_inc, rc_last;
    logic [3:0] rc_val, rc_round;

    logic ad_last_hs, ad_last_blk, pt_last_hs;

    assign ad_last_hs  = ((ad_cnt_q + BLK_ONE) == AD_LAST);
    assign ad_last_blk = (ad_cnt_q == AD_LAST);
    assign pt_last_hs  = ((pt_cnt_q + BLK_ONE) == PT_LAST);

    ascon_round_counter u_round_counter (
        .clock_i      (clock_i),
        .resetb_i     (resetb_i),
        .load_i       (rc_load),
        .load_val_i   (rc_val),
        .inc_i        (rc_inc),
        .round_o      (rc_round),
        .last_round_o (rc_last)
    );

    // State, block counters and tag flag.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q  <= S_IDLE;
            ad_cnt_q <= '0;
            pt_cnt_q <= '0;
            tag_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ad_cnt_q <= ad_cnt_d;
            pt_cnt_q <= pt_cnt_d;
            tag_q    <= tag_d;
        end
    end

    // Next state, counter loads/steps; each phase entry preloads its first round index.
    always_comb begin
        state_d  = state_q;
        ad_cnt_d = ad_cnt_q;
        pt_cnt_d = pt_cnt_q;
        tag_d    = 1'b0;
        rc_load  = 1'b0;
        rc_val   = RS_A;
        rc_inc   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d  = S_INIT;
                    ad_cnt_d = '0;
                    pt_cnt_d = '0;
                    rc_load  = 1'b1;
                    rc_val   = RS_A;
                end
            end
            S_INIT: begin
                if (rc_last) begin
                    state_d = S_AD_WAIT;
                    rc_load = 1'b1;
                    rc_val  = RS_B;
                end else begin
                    rc_inc = 1'b1;
                end
            end
            S_AD_WAIT: begin
                if (block_valid_i) begin
                    ad_cnt_d = ad_cnt_q + BLK_ONE;
                    if (rc_last) begin
                        state_d = ad_last_hs ? S_PT_WAIT : S_AD_WAIT;
                        rc_load = 1'b1;
                        rc_val  = RS_B;
                    end else begin
                        state_d = S_AD_RND;
                        rc_inc  = 1'b1;
                    end
                end
            end
            S_AD_RND: begin
                if (rc_last) begin
                    state_d = ad_last_blk ? S_PT_WAIT : S_AD_WAIT;
                    rc_load = 1'b1;
                    rc_val  = RS_B;
                end else begin
                    rc_inc = 1'b1;
                end
            end
            S_PT_WAIT: begin
                if (block_valid_i) begin
                    pt_cnt_d = pt_cnt_q + BLK_ONE;
                    if (pt_last_hs) begin
                        state_d = S_FIN;
                        rc_load = 1'b1;
                        rc_val  = RS_A;
                    end else if (rc_last) begin
                        rc_load = 1'b1;
                        rc_val  = RS_B;
                    end else begin
                        state_d = S_PT_RND;
                        rc_inc  = 1'b1;
                    end
                end
            end
            S_PT_RND: begin
                if (rc_last) begin
                    state_d = S_PT_WAIT;
                    rc_load = 1'b1;
                    rc_val  = RS_B;
                end else begin
                    rc_inc = 1'b1;
                end
            end
            S_FIN: begin
                if (rc_last) begin
                    state_d = S_DONE;
                    tag_d   = 1'b1;
                end else begin
                    rc_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath controls; only the WAIT handshake depends on block_valid_i.
    always_comb begin
        block_ready_o      = 1'b0;
        init_state_o       = 1'b0;
        en_state_o         = 1'b0;
        round_o            = 4'd0;
        en_xor_data_o      = 1'b0;
        en_xor_key_begin_o = 1'b0;
        en_xor_key_end_o   = 1'b0;
        en_xor_dsep_o      = 1'b0;
        cipher_valid_o     = 1'b0;
        tag_valid_o        = 1'b0;
        done_o             = 1'b0;
        unique case (state_q)
            S_INIT: begin
                en_state_o       = 1'b1;
                round_o          = rc_round;
                init_state_o     = (rc_round == RS_A);
                en_xor_key_end_o = rc_last;
            end
            S_AD_WAIT: begin
                block_ready_o = 1'b1;
                round_o       = rc_round;
                en_state_o    = block_valid_i;
                en_xor_data_o = block_valid_i;
                en_xor_dsep_o = block_valid_i & rc_last & ad_last_hs;
            end
            S_AD_RND: begin
                en_state_o    = 1'b1;
                round_o       = rc_round;
                en_xor_dsep_o = rc_last & ad_last_blk;
            end
            S_PT_WAIT: begin
                block_ready_o  = 1'b1;
                round_o        = rc_round;
                en_state_o     = block_valid_i & ~pt_last_hs;
                en_xor_data_o  = block_valid_i & ~pt_last_hs;
                cipher_valid_o = block_valid_i & ~pt_last_hs;
            end
            S_PT_RND: begin
                en_state_o = 1'b1;
                round_o    = rc_round;
            end
            S_FIN: begin
                en_state_o         = 1'b1;
                round_o            = rc_round;
                en_xor_key_begin_o = (rc_round == RS_A);
                en_xor_data_o      = (rc_round == RS_A);
                cipher_valid_o     = (rc_round == RS_A);
                en_xor_key_end_o   = rc_last;
            end
            S_DONE: begin
                done_o      = 1'b1;
                tag_valid_o = tag_q;
            end
            default: ;
        endcase
    end

endmodule
